nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder front-end that accepts WIDTH-bit operand pairs over a valid/ready handshake and adds them four bits per cycle through one 4-bit `ripple_carry_adder`. It holds the carry in a register between nibbles and presents the assembled sum over a valid/ready handshake. It trades latency for area: it sits directly upstream of the existing 4-bit ripple-carry stage, feeds it one nibble per cycle and consumes its sum and carry outputs.

## Interface
- `WIDTH`, default 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`  in  WIDTH  operand A (unsigned, or two's complement).
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry into bit 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  WIDTH  A + B + cin, modulo 2^WIDTH.
- `out_cout`  out  1  carry out of bit WIDTH-1.
- `out_ovf`  out  1  signed overflow.

## Operation
- N = WIDTH/4 nibbles. States: IDLE, ADD, DONE.
- **IDLE:** `in_ready`=1 (0 while `rst` is high). When `in_valid`&&`in_ready`:
  - latch `in_a`, `in_b` into shift registers; latch `in_cin` into the carry register;
  - clear the nibble counter; go to ADD.
- **ADD:** the adder sees the low nibble of each operand shift register and the carry register. On each edge:
  - the adder sum shifts into the top of the result register;
  - the adder carry replaces the carry register;
  - the operand registers shift right by 4;
  - the counter increments.
  - After the Nth ADD edge, go to DONE.
- **DONE:** `out_valid`=1. `out_cout` = carry register. `out_ovf` = (A[WIDTH-1]==B[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]), using the original operand MSBs captured at accept. When `out_valid`&&`out_ready`, go to IDLE.
- `in_ready`=0 in ADD and DONE. No overlap between operations. `in_*` are ignored outside IDLE.
- `out_sum`, `out_cout` and `out_ovf` are held stable for the whole of DONE. Their values outside DONE are don't-care but must not be X after reset.
- The carry chain crosses nibble boundaries only through the carry register; there is no combinational path from `in_*` to `out_*`.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, counter=0, carry=0, `in_ready`=0 during reset and 1 on the first cycle after `rst` deasserts.
- Latency: `out_valid` rises N+1 edges after the accepting edge (accept edge → ADD; N ADD edges; DONE visible after the Nth). WIDTH=16 gives 4 ADD cycles.
- Throughput: at best one operation per N+2 cycles. This requires `out_ready` held high, because the return from DONE to IDLE costs one cycle.
- Back-pressure: DONE persists indefinitely while `out_ready`=0, with outputs unchanged.
- `out_ready` high outside DONE has no effect.
- `rst` asserted in any state, including mid-ADD, aborts the operation on that edge. The partial result is discarded and no `out_valid` pulse follows.
- WIDTH=4: a single ADD cycle; the behaviour is otherwise identical.

## Structure
- A shared package/header holds the nibble width constant (4), the state encodings (IDLE=0, ADD=1, DONE=2) and the counter-width function clog2(N).
- One sub-module: `ripple_carry_adder` (4-bit: a, b, cin → sum, cout). Instantiate it exactly once and do not duplicate it.
- Add an elaboration check that rejects a WIDTH that is not a multiple of 4.

## Test plan
- WIDTH=16, A=0x1234, B=0x4321, cin=0, `out_ready`=1 → `out_valid` 5 edges after accept; sum=0x5555, cout=0, ovf=0; `in_ready` high the following cycle.
- A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. This exercises carry propagation through all four nibbles.
- A=0x7FFF, B=0x0001 → sum=0x8000, cout=0, ovf=1. Then A=0xFFFF, B=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- Hold `out_ready`=0 for 10 cycles in DONE, with `in_valid`=1 and new operands presented → outputs stable, `in_ready`=0, second operands not taken. Release `out_ready` → handshake completes, then the second operation starts.
- Assert `rst` for one cycle on the 2nd ADD cycle → no `out_valid`; `in_ready`=1 the cycle after `rst` drops. The next operation 0x0F0F+0x00F1 yields 0x1000 with no residue from the aborted operation.
- WIDTH=4 instance: A=0x9, B=0x9, cin=0 → sum=0x2, cout=1, ovf=1 after 2 edges.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Bits consumed by the ripple-carry stage on every ADD cycle.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Counter width for n nibbles; a single-nibble adder still needs one bit.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder stage: a + b + cin -> {cout, sum}.
module ripple_carry_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // Full-adder chain; carry rippled through a block-local variable.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit
// ripple-carry stage, carry held in a register between nibbles.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for an operand pair, in_ready high (low during rst)
// ST_ADD  | one nibble added per edge, N edges, result shifting in
// ST_DONE | result presented with out_valid, held until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    res;
    logic                carry;
    logic                a_msb;
    logic                b_msb;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    // The only adder in the block; it always looks at the low nibbles.
    ripple_carry_adder u_rca (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, nibble shifting, carry and result accumulation.
    // Outside ADD nothing moves, so the result is frozen throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            a_msb <= in_a[WIDTH-1];
            b_msb <= in_b[WIDTH-1];
            cnt   <= '0;
        end else if (state == ST_ADD) begin
            res   <= (res >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
            carry <= nib_cout;
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            cnt   <= cnt + 1'b1;
        end
    end

    // Overflow uses the operand sign bits saved at accept, since the
    // operand registers have been shifted out by the time DONE is reached.
    assign out_sum  = res;
    assign out_cout = carry;
    assign out_ovf  = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: WIDTH=16 and WIDTH=4 instances
// checked against an arithmetic reference model.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  in_a4 = '0;
    logic [3:0]  in_b4 = '0;
    logic        in_cin4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  out_sum4;
    logic        out_cout4;
    logic        out_ovf4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .in_cin    (in_cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_sum   (out_sum4),
        .out_cout  (out_cout4),
        .out_ovf   (out_ovf4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic; overflow is "true signed result
    // does not fit in w bits".
    function automatic void ref_add(input int w, input int unsigned a, input int unsigned b,
                                    input bit cin, output int unsigned s, output bit co,
                                    output bit ov);
        longint unsigned t;
        longint unsigned mask;
        longint lim, sa, sb, st;
        mask = (64'd1 << w) - 64'd1;
        t    = longint'(a) + longint'(b) + longint'(cin);
        s    = 32'(t & mask);
        co   = ((t >> w) & 64'd1) != 64'd0;
        lim  = longint'(1) << (w - 1);
        sa   = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
        st   = sa + sb + longint'(cin);
        ov   = (st >= lim) || (st < -lim);
    endfunction

    // Drives one 16-bit operation and returns what the DUT presented in DONE.
    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input int hold, output logic [15:0] s, output logic co,
                            output logic ov, output int lat, output bit ok);
        int guard;
        ok  = 1'b1;
        lat = 0;
        s   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            ok       = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        s  = out_sum;
        co = out_cout;
        ov = out_ovf;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h1111;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_sum !== 16'h0000) $display("FAIL reset_out_sum: got %h want 0000", out_sum); else n_pass++;
        n_checks++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout: got %b want 0", out_cout); else n_pass++;
        n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", out_ovf); else n_pass++;
        n_checks++; if (in_ready4 !== 1'b0) $display("FAIL reset_in_ready4: got %b want 0", in_ready4); else n_pass++;
        n_checks++; if (out_valid4 !== 1'b0) $display("FAIL reset_out_valid4: got %b want 0", out_valid4); else n_pass++;
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (in_ready4 !== 1'b1) $display("FAIL post_reset_in_ready4: got %b want 1", in_ready4); else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] av [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF};
        logic [15:0] bv [4] = '{16'h4321, 16'h0001, 16'h0001, 16'hFFFF};
        logic        cv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [4] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFF};
        logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          ok;
        for (int k = 0; k < 4; k++) begin
            run_op16(av[k], bv[k], cv[k], 0, s, co, ov, lat, ok);
            n_checks++; if (!ok) $display("FAIL dir%0d_timeout: handshake did not complete", k); else n_pass++;
            n_checks++; if (lat != 5) $display("FAIL dir%0d_latency: got %0d want 5", k, lat); else n_pass++;
            n_checks++; if (s !== es[k]) $display("FAIL dir%0d_sum: got %h want %h", k, s, es[k]); else n_pass++;
            n_checks++; if (co !== ec[k]) $display("FAIL dir%0d_cout: got %b want %b", k, co, ec[k]); else n_pass++;
            n_checks++; if (ov !== eo[k]) $display("FAIL dir%0d_ovf: got %b want %b", k, ov, eo[k]); else n_pass++;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL dir%0d_ready_after: got %b want 1", k, in_ready); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [15:0]  a, b, s;
        logic         cin, co, ov;
        int unsigned  es;
        bit           eco, eov, ok;
        int           lat;
        for (int k = 0; k < 25; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            if (k == 0) begin
                a = 16'h8000;
                b = 16'h8000;
            end
            ref_add(16, 32'(a), 32'(b), cin, es, eco, eov);
            run_op16(a, b, cin, int'($urandom_range(0, 3)), s, co, ov, lat, ok);
            n_checks++; if (!ok) $display("FAIL rnd%0d_timeout: handshake did not complete", k); else n_pass++;
            n_checks++; if (lat != 5) $display("FAIL rnd%0d_latency: got %0d want 5", k, lat); else n_pass++;
            n_checks++; if (s !== 16'(es)) $display("FAIL rnd%0d_sum: a=%h b=%h cin=%b got %h want %h", k, a, b, cin, s, 16'(es)); else n_pass++;
            n_checks++; if (co !== eco) $display("FAIL rnd%0d_cout: got %b want %b", k, co, eco); else n_pass++;
            n_checks++; if (ov !== eov) $display("FAIL rnd%0d_ovf: got %b want %b", k, ov, eov); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int unsigned es1, es2;
        bit          eco1, eov1, eco2, eov2;
        int          guard;
        ref_add(16, 32'h1111, 32'h2222, 1'b1, es1, eco1, eov1);
        ref_add(16, 32'hABCD, 32'h1357, 1'b1, es2, eco2, eov2);
        @(negedge clk);
        in_a      = 16'h1111;
        in_b      = 16'h2222;
        in_cin    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 16'hABCD;
        in_b = 16'h1357;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_first_valid: got %b want 1", out_valid); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'(es1) || out_cout !== eco1 || out_ovf !== eov1)
                $display("FAIL bp_hold%0d: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", k, out_valid, out_sum, out_cout, out_ovf, 16'(es1), eco1, eov1);
            else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_sum !== 16'(es2)) $display("FAIL bp_second_sum: got %h want %h", out_sum, 16'(es2)); else n_pass++;
        n_checks++; if (out_cout !== eco2) $display("FAIL bp_second_cout: got %b want %b", out_cout, eco2); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_cin = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [15:0] s;
        logic        co, ov;
        int          lat, seen;
        bit          ok;
        @(negedge clk);
        in_a      = 16'hAAAA;
        in_b      = 16'h5557;
        in_cin    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL abort_ready_in_rst: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_ready_after: got %b want 1", in_ready); else n_pass++;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); else n_pass++;
        run_op16(16'h0F0F, 16'h00F1, 1'b0, 0, s, co, ov, lat, ok);
        n_checks++; if (!ok) $display("FAIL abort_next_timeout: handshake did not complete"); else n_pass++;
        n_checks++; if (s !== 16'h1000) $display("FAIL abort_next_sum: got %h want 1000", s); else n_pass++;
        n_checks++; if (co !== 1'b0 || ov !== 1'b0) $display("FAIL abort_next_flags: got c=%b o=%b want c=0 o=0", co, ov); else n_pass++;
        n_checks++; if (lat != 5) $display("FAIL abort_next_latency: got %0d want 5", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic        cv [4];
        int          acc [4];
        int unsigned es;
        bit          eco, eov;
        int          guard;
        for (int k = 0; k < 4; k++) begin
            av[k] = 16'($urandom);
            bv[k] = 16'($urandom);
            cv[k] = 1'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = av[0];
        in_b      = bv[0];
        in_cin    = cv[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 acc[k] = cyc;
            @(negedge clk);
            if (k < 3) begin
                in_a   = av[k+1];
                in_b   = bv[k+1];
                in_cin = cv[k+1];
            end else begin
                in_valid = 1'b0;
            end
            guard = 0;
            while (!out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            ref_add(16, 32'(av[k]), 32'(bv[k]), cv[k], es, eco, eov);
            n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'(es) || out_cout !== eco || out_ovf !== eov)
                $display("FAIL b2b%0d_result: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b", k, out_valid, out_sum, out_cout, out_ovf, 16'(es), eco, eov);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (acc[k] - acc[k-1] != 6) $display("FAIL b2b%0d_interval: got %0d want 6", k, acc[k] - acc[k-1]); else n_pass++;
        end
    endtask

    task automatic test_width4();
        logic [3:0]  a, b;
        logic        cin;
        int unsigned es;
        bit          eco, eov;
        int          lat;
        for (int k = 0; k < 10; k++) begin
            a   = (k == 0) ? 4'h9 : 4'($urandom);
            b   = (k == 0) ? 4'h9 : 4'($urandom);
            cin = (k == 0) ? 1'b0 : 1'($urandom);
            ref_add(4, 32'(a), 32'(b), cin, es, eco, eov);
            @(negedge clk);
            in_a4      = a;
            in_b4      = b;
            in_cin4    = cin;
            in_valid4  = 1'b1;
            out_ready4 = 1'b1;
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            in_valid4 = 1'b0;
            while (!out_valid4 && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            n_checks++; if (lat != 2) $display("FAIL w4_%0d_latency: got %0d want 2", k, lat); else n_pass++;
            n_checks++; if (out_sum4 !== 4'(es) || out_cout4 !== eco || out_ovf4 !== eov)
                $display("FAIL w4_%0d_result: a=%h b=%h cin=%b got s=%h c=%b o=%b want s=%h c=%b o=%b", k, a, b, cin, out_sum4, out_cout4, out_ovf4, 4'(es), eco, eov);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (in_ready4 !== 1'b1) $display("FAIL w4_%0d_ready_after: got %b want 1", k, in_ready4); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_width4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 400000", $time);
        $fatal(1, "bench timed out");
    end

endmodule
